// File: rtl/meta_alu_sched_pkg.sv
// Shared types and default sizing for the metadata ALU scheduler.
package meta_alu_sched_pkg;

    localparam int NUM_REQ_DEF    = 2;
    localparam int ACTION_LEN_DEF = 25;
    localparam int META_LEN_DEF   = 256;
    localparam int COMP_LEN_DEF   = 100;
    localparam int TIMEOUT_DEF    = 15;

    localparam int DW   = META_LEN_DEF + COMP_LEN_DEF;
    localparam int ID_W = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/meta_alu_sched_if.sv
// Requester, ALU and result-side signals of the scheduler; master is the scheduler itself.
interface meta_alu_sched_if
    import meta_alu_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ACTION_LEN = ACTION_LEN_DEF,
    parameter int DATA_W     = DW,
    parameter int IDX_W      = ID_W
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_W-1:0]     req_meta;
    logic [NUM_REQ*ACTION_LEN-1:0] req_action;

    logic [DATA_W-1:0]             alu_meta;
    logic [ACTION_LEN-1:0]         alu_action;
    logic                          alu_valid;
    logic [DATA_W-1:0]             alu_res;
    logic                          alu_res_valid;

    logic [DATA_W-1:0]             out_meta;
    logic [IDX_W-1:0]              out_id;
    logic                          out_valid;
    logic                          out_ready;

    logic                          busy;
    logic                          err_timeout;

    modport master (
        input  req_valid, req_meta, req_action, alu_res, alu_res_valid, out_ready,
        output req_ready, alu_meta, alu_action, alu_valid, out_meta, out_id, out_valid,
               busy, err_timeout
    );

    modport slave (
        output req_valid, req_meta, req_action, alu_res, alu_res_valid, out_ready,
        input  req_ready, alu_meta, alu_action, alu_valid, out_meta, out_id, out_valid,
               busy, err_timeout
    );
endinterface

// File: rtl/meta_alu_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no backpressure of its own.
module meta_alu_sched_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr_i) + off) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/meta_alu_sched.sv
// Shares one non-pipelined metadata ALU between NUM_REQ requesters, one job in flight.
// Accept->issue 1 cycle, result->out_valid 1 cycle; result held until out_ready, requesters stalled meanwhile.
module meta_alu_sched
    import meta_alu_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ACTION_LEN = ACTION_LEN_DEF,
    parameter int META_LEN   = META_LEN_DEF,
    parameter int COMP_LEN   = COMP_LEN_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    meta_alu_sched_if.master sif
);
    localparam int DATA_W = META_LEN + COMP_LEN;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [DATA_W-1:0]     meta;
        logic [ACTION_LEN-1:0] action;
        logic [IDX_W-1:0]      id;
    } job_t;

    typedef struct packed {
        logic [DATA_W-1:0] meta;
        logic [IDX_W-1:0]  id;
        logic              vld;
    } res_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    job_t             job_q, job_d;
    res_t             res_q, res_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    meta_alu_sched_rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
        .req_i (sif.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            job_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            job_q    <= job_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        job_d         = job_q;
        res_d         = res_q;
        err_d         = err_q;
        sif.req_ready = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    sif.req_ready = gnt_oh;
                    job_d.meta    = sif.req_meta[int'(gnt_idx)*DATA_W +: DATA_W];
                    job_d.action  = sif.req_action[int'(gnt_idx)*ACTION_LEN +: ACTION_LEN];
                    job_d.id      = gnt_idx;
                    rr_ptr_d      = IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result on the final allowed cycle still wins over the timeout.
                if (sif.alu_res_valid) begin
                    res_d.meta = sif.alu_res;
                    res_d.id   = job_q.id;
                    res_d.vld  = 1'b1;
                    state_d    = ST_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (sif.out_ready) begin
                    res_d.vld = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sif.alu_valid   = (state_q == ST_ISSUE);
    assign sif.alu_meta    = job_q.meta;
    assign sif.alu_action  = job_q.action;
    assign sif.out_meta    = res_q.meta;
    assign sif.out_id      = res_q.id;
    assign sif.out_valid   = res_q.vld;
    assign sif.busy        = (state_q != ST_IDLE);
    assign sif.err_timeout = err_q;

endmodule

// File: tb/tb_meta_alu_sched.sv
// Directed and randomized checks of meta_alu_sched against a transaction-level model and ALU stub.
module tb_meta_alu_sched;
    localparam int NUM_REQ    = 2;
    localparam int ACTION_LEN = 25;
    localparam int META_LEN   = 256;
    localparam int COMP_LEN   = 100;
    localparam int TIMEOUT    = 15;
    localparam int DW         = META_LEN + COMP_LEN;
    localparam int ID_W       = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    meta_alu_sched_if #(.NUM_REQ(NUM_REQ), .ACTION_LEN(ACTION_LEN), .DATA_W(DW), .IDX_W(ID_W)) bus ();

    meta_alu_sched #(
        .NUM_REQ(NUM_REQ), .ACTION_LEN(ACTION_LEN), .META_LEN(META_LEN),
        .COMP_LEN(COMP_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stray_at = -1;
    logic [DW-1:0] stray_val = '0;
    bit stub_en = 1'b0;
    int stub_lat = 5;
    int exp_ptr = 0;
    bit exp_err = 1'b0;
    int served [NUM_REQ];
    logic [DW-1:0] last_out = '0;
    logic [DW-1:0] rq_m [NUM_REQ];
    logic [ACTION_LEN-1:0] rq_a [NUM_REQ];

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] m, input logic [ACTION_LEN-1:0] a);
        return {m[DW-9:0], m[DW-1:DW-8]} ^ DW'(a);
    endfunction

    function automatic logic [DW-1:0] rnd_dw();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < (DW + 31) / 32; k++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    // Rotating priority: lowest valid index at or above the pointer, else lowest valid overall.
    function automatic int model_grant(input logic [NUM_REQ-1:0] vld);
        for (int i = exp_ptr; i < NUM_REQ; i++) if (vld[i]) return i;
        for (int i = 0; i < exp_ptr; i++) if (vld[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_meta[i*DW +: DW]                 = rq_m[i];
            bus.req_action[i*ACTION_LEN +: ACTION_LEN] = rq_a[i];
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"},      DW'(bus.busy), '0);
        chk({tag, "_alu_valid"}, DW'(bus.alu_valid), '0);
        chk({tag, "_out_valid"}, DW'(bus.out_valid), '0);
        chk({tag, "_err"},       DW'(bus.err_timeout), '0);
        chk({tag, "_req_ready"}, DW'(bus.req_ready), '0);
        chk({tag, "_out_meta"},  bus.out_meta, '0);
        chk({tag, "_out_id"},    DW'(bus.out_id), '0);
        chk({tag, "_alu_meta"},  bus.alu_meta, '0);
        chk({tag, "_alu_act"},   DW'(bus.alu_action), '0);
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge after the job.
    task automatic run_job(input logic [NUM_REQ-1:0] vld, input int hold, input int lat,
                           input bit to_mode, input bit stray_hold);
        int g, c;
        bit ok;
        logic [DW-1:0] am, em;
        logic [ACTION_LEN-1:0] aa;
        logic [ID_W-1:0] seen_id;
        g  = model_grant(vld);
        am = rq_m[g];
        aa = rq_a[g];
        em = alu_fn(am, aa);
        stub_en  = !to_mode;
        stub_lat = lat;
        bus.req_valid = vld;
        #1;
        chk("accept_ready", DW'(bus.req_ready), DW'(NUM_REQ'(1) << g));
        @(negedge clk);
        exp_ptr = (g + 1) % NUM_REQ;
        rq_m[g] = rnd_dw();
        rq_a[g] = ACTION_LEN'($urandom);
        apply_reqs();
        #1;
        chk("issue_valid",  DW'(bus.alu_valid), DW'(1));
        chk("issue_meta",   bus.alu_meta, am);
        chk("issue_action", DW'(bus.alu_action), DW'(aa));
        chk("issue_ready",  DW'(bus.req_ready), '0);
        c  = 0;
        ok = 1'b1;
        if (to_mode) begin
            while (!bus.err_timeout && c < 4 * TIMEOUT) begin
                @(negedge clk);
                c++;
                if (bus.out_valid) ok = 1'b0;
            end
            chk("timeout_cycles", DW'(c), DW'(TIMEOUT + 1));
            chk("timeout_no_out", DW'(ok), DW'(1));
            chk("timeout_idle",   DW'(bus.busy), '0);
            exp_err = 1'b1;
        end else begin
            while (!bus.out_valid && c < 4 * TIMEOUT) begin
                @(negedge clk);
                c++;
                if (bus.req_ready != '0) ok = 1'b0;
            end
            chk("result_latency", DW'(c), DW'(lat + 1));
            chk("out_meta", bus.out_meta, em);
            chk("out_id",   DW'(bus.out_id), DW'(g));
            seen_id = bus.out_id;
            for (int h = 0; h < hold; h++) begin
                if (h == 0 && stray_hold) begin
                    stray_at  = cyc + 1;
                    stray_val = rnd_dw();
                end
                @(negedge clk);
                if (bus.out_meta !== em || int'(bus.out_id) != g || !bus.out_valid ||
                    !bus.busy || bus.req_ready != '0) ok = 1'b0;
            end
            chk("hold_stable", DW'(ok), DW'(1));
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("release_valid", DW'(bus.out_valid), '0);
            chk("release_idle",  DW'(bus.busy), '0);
            served[int'(seen_id)]++;
            last_out = em;
        end
        chk("err_sticky", DW'(bus.err_timeout), DW'(exp_err));
    endtask

    // ALU stub: answers each issue after stub_lat cycles, plus one-off stray pulses on request.
    initial begin
        int due;
        logic [DW-1:0] due_res;
        due = -1;
        due_res = '0;
        bus.alu_res_valid = 1'b0;
        bus.alu_res = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.alu_res_valid = 1'b0;
            if (bus.alu_valid && stub_en) begin
                due     = cyc + stub_lat;
                due_res = alu_fn(bus.alu_meta, bus.alu_action);
            end
            if (due >= 0 && cyc == due) begin
                bus.alu_res_valid = 1'b1;
                bus.alu_res       = due_res;
                due = -1;
            end
            if (cyc == stray_at) begin
                bus.alu_res_valid = 1'b1;
                bus.alu_res       = stray_val;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] vld;
        int g6;
        rst_n = 1'b0;
        bus.req_valid  = '0;
        bus.req_meta   = '0;
        bus.req_action = '0;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_m[i] = rnd_dw();
            rq_a[i] = ACTION_LEN'($urandom);
            served[i] = 0;
        end
        apply_reqs();
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", DW'(bus.busy), '0);

        // Single requester, fixed action word, 5-cycle ALU.
        rq_a[0] = 25'h1800000;
        apply_reqs();
        run_job(2'b01, 0, 5, 1'b0, 1'b0);

        // Both requesters always valid: grants rotate and each is served equally.
        for (int i = 0; i < NUM_REQ; i++) served[i] = 0;
        for (int j = 0; j < 8; j++) run_job(2'b11, 0, 5, 1'b0, 1'b0);
        chk("rr_served0", DW'(served[0]), DW'(4));
        chk("rr_served1", DW'(served[1]), DW'(4));

        // Long downstream backpressure.
        run_job(2'b01, 10, 5, 1'b0, 1'b0);

        // Stray ALU pulse while holding a result, then while idle.
        run_job(2'b10, 4, 3, 1'b0, 1'b1);
        bus.req_valid = '0;
        stray_at  = cyc + 1;
        stray_val = rnd_dw();
        repeat (2) @(negedge clk);
        chk("idle_stray_busy",  DW'(bus.busy), '0);
        chk("idle_stray_valid", DW'(bus.out_valid), '0);
        chk("idle_stray_meta",  bus.out_meta, last_out);

        // ALU never answers, then a normal job with the sticky error still set.
        run_job(2'b01, 0, 0, 1'b1, 1'b0);
        run_job(2'b10, 0, 5, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            vld = NUM_REQ'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = '0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                chk("rand_idle", DW'(bus.busy), '0);
            end
            run_job(vld, $urandom_range(0, 3), $urandom_range(1, 13), 1'b0, 1'b0);
        end

        // Reset while waiting on the ALU; its late result must be ignored.
        g6 = model_grant(2'b01);
        stub_en = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        chk("rst_job_accept", DW'(bus.req_ready), DW'(NUM_REQ'(1) << g6));
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        chk("rst_job_busy", DW'(bus.busy), DW'(1));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("midrst");
        rst_n = 1'b1;
        stray_at  = cyc + 2;
        stray_val = rnd_dw();
        exp_ptr = 0;
        exp_err = 1'b0;
        repeat (4) @(negedge clk);
        reset_checks("postrst");
        run_job(2'b11, 0, 5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
